// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: command encodings, init sequencer states and the
// default timing constants also used by the refresh and command schedulers.
package ddr2_pkg;

    // {csbar, rasbar, casbar, webar}
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_PRE      = 4'b0010;
    localparam logic [3:0] CMD_MRS      = 4'b0000;
    localparam logic [3:0] CMD_REF      = 4'b0001;
    localparam logic [3:0] CMD_DESELECT = 4'b1111;

    localparam int T_CKE_WAIT_DEF = 200;
    localparam int T_NOP400_DEF   = 154;
    localparam int T_RP_DEF       = 6;
    localparam int T_MRD_DEF      = 2;
    localparam int T_RFC_DEF      = 50;
    localparam int T_DLL_DEF      = 200;

    localparam logic [12:0] MR_VAL_DEF      = 13'h0442;
    localparam logic [12:0] EMR_VAL_DEF     = 13'h0004;
    localparam logic [12:0] A_PRE_ALL       = 13'h0400;
    localparam logic [12:0] MR_DLL_RESET    = 13'h0100;
    localparam logic [12:0] EMR_OCD_DEFAULT = 13'h0380;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CKE_LOW,
        ST_NOP400,
        ST_PRE1,
        ST_EMRS2,
        ST_EMRS3,
        ST_EMRS1_EN,
        ST_MRS_DLLRST,
        ST_PRE2,
        ST_REF1,
        ST_REF2,
        ST_MRS,
        ST_OCD_DEF,
        ST_OCD_EXIT,
        ST_WAIT_DLL,
        ST_DONE
    } init_state_t;

    function automatic int max_of(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/ddr2_wait_counter.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module ddr2_wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/ddr2_init_engine.sv
// DDR2 power-up / initialization sequencer; each step issues its command on the
// entering edge and holds NOP until its wait expires.
module ddr2_init_engine
    import ddr2_pkg::*;
#(
    parameter int          T_CKE_WAIT = T_CKE_WAIT_DEF,
    parameter int          T_NOP400   = T_NOP400_DEF,
    parameter int          T_RP       = T_RP_DEF,
    parameter int          T_MRD      = T_MRD_DEF,
    parameter int          T_RFC      = T_RFC_DEF,
    parameter int          T_DLL      = T_DLL_DEF,
    parameter logic [12:0] MR_VAL     = MR_VAL_DEF,
    parameter logic [12:0] EMR_VAL    = EMR_VAL_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        initddr,
    output logic        ready,
    output logic        cke,
    output logic        csbar,
    output logic        rasbar,
    output logic        casbar,
    output logic        webar,
    output logic [1:0]  ba,
    output logic [12:0] a,
    output logic        odt
);

    localparam int MAX_WAIT = max_of(max_of(max_of(T_CKE_WAIT, T_NOP400), max_of(T_RP, T_MRD)),
                                     max_of(T_RFC, T_DLL));
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    init_state_t r_state;
    logic        r_ready;
    logic        r_cke;
    logic [3:0]  r_cmd;
    logic [1:0]  r_ba;
    logic [12:0] r_a;

    init_state_t      w_next_state;
    logic [3:0]       w_next_cmd;
    logic [1:0]       w_next_ba;
    logic [12:0]      w_next_a;
    logic [CNT_W-1:0] w_next_wait;
    logic [CNT_W-1:0] w_step_value;
    logic             w_step_done;
    logic             w_dll_done;
    logic             w_in_sequence;
    logic             w_step_advance;
    logic             w_step_load;
    logic             w_dll_load;

    // A step with wait T is loaded with T-1 on its issuing edge; CKE_LOW gets the
    // full count because its start edge still shows idle outputs.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_next_cmd   = CMD_NOP;
        w_next_ba    = 2'd0;
        w_next_a     = 13'h0000;
        w_next_wait  = '0;
        case (r_state)
            ST_CKE_LOW:    begin w_next_state = ST_NOP400;     w_next_wait = CNT_W'(T_NOP400 - 1); end
            ST_NOP400:     begin w_next_state = ST_PRE1;       w_next_cmd = CMD_PRE; w_next_a = A_PRE_ALL;
                                 w_next_wait = CNT_W'(T_RP - 1); end
            ST_PRE1:       begin w_next_state = ST_EMRS2;      w_next_cmd = CMD_MRS; w_next_ba = 2'd2;
                                 w_next_wait = CNT_W'(T_MRD - 1); end
            ST_EMRS2:      begin w_next_state = ST_EMRS3;      w_next_cmd = CMD_MRS; w_next_ba = 2'd3;
                                 w_next_wait = CNT_W'(T_MRD - 1); end
            ST_EMRS3:      begin w_next_state = ST_EMRS1_EN;   w_next_cmd = CMD_MRS; w_next_ba = 2'd1;
                                 w_next_a = EMR_VAL; w_next_wait = CNT_W'(T_MRD - 1); end
            ST_EMRS1_EN:   begin w_next_state = ST_MRS_DLLRST; w_next_cmd = CMD_MRS;
                                 w_next_a = MR_VAL | MR_DLL_RESET; w_next_wait = CNT_W'(T_MRD - 1); end
            ST_MRS_DLLRST: begin w_next_state = ST_PRE2;       w_next_cmd = CMD_PRE; w_next_a = A_PRE_ALL;
                                 w_next_wait = CNT_W'(T_RP - 1); end
            ST_PRE2:       begin w_next_state = ST_REF1;       w_next_cmd = CMD_REF;
                                 w_next_wait = CNT_W'(T_RFC - 1); end
            ST_REF1:       begin w_next_state = ST_REF2;       w_next_cmd = CMD_REF;
                                 w_next_wait = CNT_W'(T_RFC - 1); end
            ST_REF2:       begin w_next_state = ST_MRS;        w_next_cmd = CMD_MRS; w_next_a = MR_VAL;
                                 w_next_wait = CNT_W'(T_MRD - 1); end
            ST_MRS:        begin w_next_state = ST_OCD_DEF;    w_next_cmd = CMD_MRS; w_next_ba = 2'd1;
                                 w_next_a = EMR_VAL | EMR_OCD_DEFAULT; w_next_wait = CNT_W'(T_MRD - 1); end
            ST_OCD_DEF:    begin w_next_state = ST_OCD_EXIT;   w_next_cmd = CMD_MRS; w_next_ba = 2'd1;
                                 w_next_a = EMR_VAL; w_next_wait = CNT_W'(T_MRD - 1); end
            ST_OCD_EXIT:   begin w_next_state = ST_WAIT_DLL; end
            default:       ;
        endcase
    end

    assign w_in_sequence  = (r_state inside {[ST_CKE_LOW:ST_OCD_EXIT]});
    assign w_step_advance = w_in_sequence && w_step_done;
    assign w_step_load    = ((r_state == ST_IDLE) && initddr) || w_step_advance;
    assign w_step_value   = (r_state == ST_IDLE) ? CNT_W'(T_CKE_WAIT) : w_next_wait;
    assign w_dll_load     = w_step_advance && (r_state == ST_EMRS1_EN);

    ddr2_wait_counter #(.WIDTH(CNT_W)) u_step_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_step_load),
        .i_value (w_step_value),
        .o_done  (w_step_done)
    );

    ddr2_wait_counter #(.WIDTH(CNT_W)) u_dll_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_dll_load),
        .i_value (CNT_W'(T_DLL - 1)),
        .o_done  (w_dll_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_cke   <= 1'b0;
            r_cmd   <= CMD_DESELECT;
            r_ba    <= 2'd0;
            r_a     <= 13'h0000;
        end else begin
            r_cmd <= (r_state == ST_IDLE) ? CMD_DESELECT : CMD_NOP;
            r_ba  <= 2'd0;
            r_a   <= 13'h0000;
            case (r_state)
                ST_IDLE: begin
                    if (initddr) r_state <= ST_CKE_LOW;
                end
                ST_WAIT_DLL: begin
                    if (w_dll_done) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                    end
                end
                ST_DONE: ;
                default: begin
                    if (w_step_done) begin
                        if (r_state == ST_CKE_LOW) r_cke <= 1'b1;
                        r_cmd <= w_next_cmd;
                        r_ba  <= w_next_ba;
                        r_a   <= w_next_a;
                        // Skip WAIT_DLL when the DLL lock time has already elapsed.
                        if ((r_state == ST_OCD_EXIT) && w_dll_done) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= w_next_state;
                        end
                    end
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign cke    = r_cke;
    assign csbar  = r_cmd[3];
    assign rasbar = r_cmd[2];
    assign casbar = r_cmd[1];
    assign webar  = r_cmd[0];
    assign ba     = r_ba;
    assign a      = r_a;
    assign odt    = 1'b0;

endmodule

// File: doc/ddr2_init_engine.md
Name: ddr2_init_engine

Overview:
- Sequences the JEDEC DDR2 power-up and initialization for the MT47H32M16 device, starting when `initddr` is asserted.
- Issues NOP, PRECHARGE ALL, EMRS2/3, EMRS1, MRS (with DLL reset), two AUTO REFRESH, MRS, then OCD default and OCD exit.
- Raises `ready` when the device may accept normal traffic.
- Sits inside ddr2_controller; its command/address outputs are muxed onto the pad drivers until `ready` is set.

Parameters:
- T_CKE_WAIT, 200, cycles CKE held low after start (scaled for simulation; silicon needs 200 us).
- T_NOP400, 154, cycles of NOP with CKE high before the first PRECHARGE (400 ns at a 2.6 ns clock).
- T_RP, 6, cycles from PRECHARGE to the next command.
- T_MRD, 2, cycles from MRS/EMRS to the next command.
- T_RFC, 50, cycles from AUTO REFRESH to the next command.
- T_DLL, 200, minimum cycles from the DLL-reset MRS to `ready`.
- MR_VAL, 13'h0442, mode register value: BL4, sequential, CL4, WR3, DLL reset off.
- EMR_VAL, 13'h0004, EMR1 value: DLL enabled, full drive, Rtt 75 ohm, OCD exit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- initddr  in  1  start request, sampled only in IDLE.
- ready  out  1  initialization complete; sticky until reset.
- cke  out  1  clock enable.
- csbar  out  1  chip select, active low.
- rasbar  out  1  RAS, active low.
- casbar  out  1  CAS, active low.
- webar  out  1  WE, active low.
- ba  out  2  bank address.
- a  out  13  address / mode bits.
- odt  out  1  on-die termination; always 0.

Behaviour:
- All outputs are registered.
- Reset values: ready=0, cke=0, csbar=1, rasbar=casbar=webar=1, ba=0, a=0, odt=0.
- Encodings as {csbar,rasbar,casbar,webar}:
  - NOP = 0111; PRE = 0010 with a[10]=1 (all banks); MRS/EMRS = 0000; REF = 0001.
  - ba and a are 0 except on PRE and MRS/EMRS cycles.
- Each command is driven for exactly one cycle; every other non-IDLE cycle drives NOP.
- Timing is deterministic. A command issued in cycle N is followed by the next command in exactly cycle N+T, with T the wait listed for that command.
- States and transitions:
  - IDLE: outputs stay at reset values. If `initddr`=1 at edge k, go to CKE_LOW.
  - CKE_LOW: from cycle k+1, NOP with cke=0 for T_CKE_WAIT cycles.
  - NOP400: cke=1 (remains 1 thereafter); NOP for T_NOP400 cycles.
  - PRE1: PRE; wait T_RP.
  - EMRS2: ba=2, a=0; wait T_MRD.
  - EMRS3: ba=3, a=0; wait T_MRD.
  - EMRS1_EN: ba=1, a=EMR_VAL; wait T_MRD.
  - MRS_DLLRST: ba=0, a=MR_VAL|13'h0100; wait T_MRD. Also loads a separate DLL counter with T_DLL.
  - PRE2: PRE; wait T_RP.
  - REF1: REF; wait T_RFC.
  - REF2: REF; wait T_RFC.
  - MRS: ba=0, a=MR_VAL; wait T_MRD.
  - OCD_DEF: ba=1, a=EMR_VAL|13'h0380; wait T_MRD.
  - OCD_EXIT: ba=1, a=EMR_VAL; wait T_MRD.
  - WAIT_DLL: NOP until the DLL counter expires.
  - DONE: ready=1, NOP, cke=1, held until reset.
- `ready` rises at the later of (OCD_EXIT issue + T_MRD) and (MRS_DLLRST issue + T_DLL).
- `initddr` is ignored outside IDLE, including pulses, holds and toggles.
- A one-cycle `initddr` pulse is sufficient to start the sequence.
- `reset` in any state returns to IDLE with reset output values on the next cycle. The counters are cleared, and a fresh `initddr` restarts the sequence from CKE_LOW.
- Counter widths are sized for the largest parameter via $clog2. Parameters must be at least 1.

Decomposition:
- Shared package ddr2_pkg holds:
  - the 4-bit command encodings (NOP, PRE, MRS, REF, DESELECT);
  - the init state enum;
  - default timing constants, also reused by the refresh and command schedulers.
- One sub-module, ddr2_wait_counter: a loadable down-counter with a `done` flag, instantiated twice (step wait and DLL wait).

Test Plan:
- Reset check: hold reset 5 cycles -> every output at its reset value; ready=0, cke=0, csbar=1.
- Full default sequence with `initddr` sampled at edge k:
  - cke=1 from k+201.
  - Commands at k+355 PRE, 361 EMRS2, 363 EMRS3, 365 EMRS1(a=0x004), 367 MRS(a=0x542), 369 PRE, 375 REF, 425 REF, 475 MRS(a=0x442), 477 EMRS1(a=0x384), 479 EMRS1(a=0x004).
  - ready=1 at k+567. The DUT drives the mt47h32m16_37e model with no model timing violations.
- Sequence-limited ready: T_DLL=50 override -> ready asserts at k+481 (sequence end dominates).
- Start-request robustness: one-cycle `initddr` pulse starts the sequence. Toggling `initddr` during the sequence and after ready leaves command timing unchanged and keeps ready=1.
- Reset mid-sequence: reset at k+400 (between REFs) -> outputs return to reset values one cycle later. Re-asserting `initddr` repeats the full timeline from CKE_LOW.
- Bus checks: odt=0 throughout, and exactly 11 non-NOP commands are issued per init.
